// File: rtl/milestone_mac_array.sv
// rtl/milestone_mac_array.sv - multi-channel multiply-accumulate engine with valid/ready handshakes
//
// Purpose: each of NUM_CH channels accumulates +/- sample*coef over NUM_TAPS accepted
// beats, starting from a common loadable value. It then presents the raw sums and a
// shifted, clipped pixel value for each channel until the consumer accepts them.
//
// Ports:
//   Clock_50   - system clock, rising edge
//   Resetn     - asynchronous active-low reset
//   start      - load init_value into all channels and begin accumulating (IDLE only)
//   clear      - synchronous abort to IDLE; accumulators hold
//   init_value - signed start value shared by all channels
//   in_valid   - input beat present
//   in_ready   - engine accepts a beat (ACCUM state)
//   sample     - per-channel signed samples, channel 0 at LSBs
//   coef       - per-channel signed coefficients, channel 0 at LSBs
//   subtract   - beat's products are subtracted instead of added
//   out_valid  - results valid, held until out_ready
//   out_ready  - consumer accepts results
//   acc_raw    - per-channel signed accumulator contents
//   result     - per-channel clip(acc >>> OUT_SHIFT, 0, 2^OUT_W-1)
//   busy       - high whenever the engine is not IDLE
module milestone_mac_array #(
    parameter int NUM_CH    = 3,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int ACC_W     = 32,
    parameter int NUM_TAPS  = 6,
    parameter int OUT_SHIFT = 8,
    parameter int OUT_W     = 8
) (
    input  logic                     Clock_50,
    input  logic                     Resetn,
    input  logic                     start,
    input  logic                     clear,
    input  logic [ACC_W-1:0]         init_value,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] sample,
    input  logic [NUM_CH*COEF_W-1:0] coef,
    input  logic                     subtract,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*ACC_W-1:0]  acc_raw,
    output logic [NUM_CH*OUT_W-1:0]  result,
    output logic                     busy
);

    localparam int CNT_W = $clog2(NUM_TAPS + 1);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] tap_cnt_q;
    logic             s1_valid_q;
    logic             s1_sub_q;

    logic accept;
    logic load_init;
    logic acc_update;

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);

    assign accept     = in_valid && in_ready;
    assign load_init  = (state_q == ST_IDLE) && start && !clear;
    // clear drops the pending stage-1 product, so it must not reach the accumulators
    assign acc_update = s1_valid_q && !clear;

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= ST_IDLE;
            tap_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_sub_q   <= 1'b0;
        end else if (clear) begin
            state_q    <= ST_IDLE;
            s1_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    s1_valid_q <= 1'b0;
                    if (start) begin
                        tap_cnt_q <= '0;
                        state_q   <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    s1_valid_q <= accept;
                    if (accept) begin
                        s1_sub_q  <= subtract;
                        tap_cnt_q <= tap_cnt_q + 1'b1;
                        if (tap_cnt_q == CNT_W'(NUM_TAPS - 1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // the first DRAIN edge folds in the last product; present
                    // results only once stage 1 is empty
                    s1_valid_q <= 1'b0;
                    if (!s1_valid_q) begin
                        state_q <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    s1_valid_q <= 1'b0;
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [PROD_W-1:0] prod_full;
        logic signed [ACC_W-1:0]  prod_ext;
        logic signed [ACC_W-1:0]  prod_q;
        logic signed [ACC_W-1:0]  acc_q;
        logic signed [ACC_W-1:0]  acc_d;
        logic signed [ACC_W-1:0]  shifted;
        logic [OUT_W-1:0]         res_ch;

        assign prod_full = $signed(sample[c*DATA_W +: DATA_W]) * $signed(coef[c*COEF_W +: COEF_W]);
        assign prod_ext  = ACC_W'(prod_full);

        always_comb begin
            acc_d = acc_q;
            if (load_init) begin
                acc_d = $signed(init_value);
            end else if (acc_update) begin
                acc_d = s1_sub_q ? (acc_q - prod_q) : (acc_q + prod_q);
            end
        end

        always_ff @(posedge Clock_50 or negedge Resetn) begin
            if (!Resetn) begin
                prod_q <= '0;
                acc_q  <= '0;
            end else begin
                if (accept && !clear) begin
                    prod_q <= prod_ext;
                end
                acc_q <= acc_d;
            end
        end

        always_comb begin
            shifted = acc_q >>> OUT_SHIFT;
            res_ch  = shifted[OUT_W-1:0];
            if (shifted < 0) begin
                res_ch = '0;
            end else if (shifted > RES_MAX) begin
                res_ch = '1;
            end
        end

        assign acc_raw[c*ACC_W +: ACC_W] = acc_q;
        assign result[c*OUT_W +: OUT_W]  = res_ch;
    end

endmodule

// File: tb/tb_milestone_mac_array.sv
// tb/tb_milestone_mac_array.sv - directed self-checking bench for milestone_mac_array
module tb_milestone_mac_array;

    logic        Clock_50;
    logic        Resetn;
    logic        start;
    logic        clear;
    logic [31:0] init_value;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] sample;
    logic [47:0] coef;
    logic        subtract;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] acc_raw;
    logic [23:0] result;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    milestone_mac_array dut (
        .Clock_50  (Clock_50),
        .Resetn    (Resetn),
        .start     (start),
        .clear     (clear),
        .init_value(init_value),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sample    (sample),
        .coef      (coef),
        .subtract  (subtract),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_raw   (acc_raw),
        .result    (result),
        .busy      (busy)
    );

    initial begin
        Clock_50 = 1'b0;
        forever #5 Clock_50 = ~Clock_50;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock_50);
        #1;
    endtask

    task automatic do_start(input logic [31:0] init);
        init_value = init;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_ready", 96'(in_ready), 96'd1);
    endtask

    task automatic run_beats(input int n, input logic [47:0] s, input logic [47:0] c,
                             input logic sub, input bit gaps);
        int taken = 0;
        int guard = 0;
        logic took;
        while (taken < n && guard < 100) begin
            sample   = s;
            coef     = c;
            subtract = sub;
            in_valid = gaps ? (guard % 2 == 0) : 1'b1;
            took     = in_valid && in_ready;
            tick();
            if (took) taken++;
            guard++;
        end
        in_valid = 1'b0;
        chk("beats_accepted", 96'(taken), 96'(n));
    endtask

    // called just after the edge that accepted the final beat
    task automatic finish_run(input string tag, input logic [95:0] exp_acc, input logic [23:0] exp_res);
        chk({tag, "_drain_in_ready"}, 96'(in_ready), 96'd0);
        chk({tag, "_ov_edge1"}, 96'(out_valid), 96'd0);
        tick();
        chk({tag, "_ov_edge2_pre"}, 96'(out_valid), 96'd0);
        tick();
        chk({tag, "_ov_edge2"}, 96'(out_valid), 96'd1);
        chk({tag, "_acc_raw"}, acc_raw, exp_acc);
        chk({tag, "_result"}, 96'(result), 96'(exp_res));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_busy"}, 96'(busy), 96'd0);
        chk({tag, "_idle_ov"}, 96'(out_valid), 96'd0);
    endtask

    logic [95:0] exp_acc;
    logic [95:0] held_acc;
    logic [23:0] held_res;

    initial begin
        Resetn = 1'b0; start = 1'b0; clear = 1'b0; init_value = '0;
        in_valid = 1'b0; sample = '0; coef = '0; subtract = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 96'(in_ready), 96'd0);
        chk("rst_out_valid", 96'(out_valid), 96'd0);
        chk("rst_busy", 96'(busy), 96'd0);
        chk("rst_acc_raw", acc_raw, 96'd0);
        chk("rst_result", 96'(result), 96'd0);
        Resetn = 1'b1;
        tick();

        // basic: 6 * 10 * 256 = 15360, >>8 = 60
        do_start(32'd0);
        chk("basic_busy", 96'(busy), 96'd1);
        run_beats(6, {3{16'd10}}, {3{16'd256}}, 1'b0, 1'b0);
        exp_acc = {3{32'd15360}};
        finish_run("basic", exp_acc, {3{8'd60}});

        // subtract / clip low: 1000 - 6*200 = -200
        do_start(32'd1000);
        run_beats(6, {3{16'd2}}, {3{16'd100}}, 1'b1, 1'b0);
        exp_acc = {3{32'hFFFF_FF38}};
        finish_run("sub", exp_acc, 24'd0);

        // clip high: 6 * 256000 = 1536000, >>8 = 6000 -> 255
        do_start(32'd0);
        run_beats(6, {3{16'd1000}}, {3{16'd256}}, 1'b0, 1'b0);
        exp_acc = {3{32'd1536000}};
        finish_run("cliphi", exp_acc, {3{8'd255}});

        // per-channel: coef {512, 0, -1}, sample 100
        do_start(32'd0);
        run_beats(6, {3{16'd100}}, {16'd512, 16'd0, 16'hFFFF}, 1'b0, 1'b0);
        exp_acc = {32'd307200, 32'd0, 32'hFFFF_FDA8};
        finish_run("perch", exp_acc, {8'd255, 8'd0, 8'd0});

        // backpressure: gapped input, 6 * 3 * 512 = 9216 -> 36
        do_start(32'd0);
        run_beats(6, {3{16'd3}}, {3{16'd512}}, 1'b0, 1'b1);
        tick();
        tick();
        chk("bp_ov", 96'(out_valid), 96'd1);
        exp_acc = {3{32'd9216}};
        chk("bp_acc", acc_raw, exp_acc);
        held_acc = acc_raw;
        held_res = result;
        chk("bp_res", 96'(held_res), 96'({3{8'd36}}));
        start = 1'b1;
        init_value = 32'd777;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_ov", 96'(out_valid), 96'd1);
            chk("bp_hold_acc", acc_raw, held_acc);
            chk("bp_hold_in_ready", 96'(in_ready), 96'd0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_rel_busy", 96'(busy), 96'd0);
        chk("bp_rel_ov", 96'(out_valid), 96'd0);
        chk("bp_rel_acc", acc_raw, held_acc);

        // abort with clear after 3 beats; acc holds the two products already folded in
        do_start(32'd0);
        run_beats(3, {3{16'd10}}, {3{16'd256}}, 1'b0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_busy", 96'(busy), 96'd0);
        chk("clr_in_ready", 96'(in_ready), 96'd0);
        exp_acc = {3{32'd5120}};
        chk("clr_acc_hold", acc_raw, exp_acc);
        tick();
        tick();
        chk("clr_no_ov", 96'(out_valid), 96'd0);
        chk("clr_acc_hold2", acc_raw, exp_acc);

        // fresh run after abort: 100 + 15360 = 15460 -> 60
        do_start(32'd100);
        run_beats(6, {3{16'd10}}, {3{16'd256}}, 1'b0, 1'b0);
        exp_acc = {3{32'd15460}};
        finish_run("postclr", exp_acc, {3{8'd60}});

        // asynchronous reset mid-ACCUM
        do_start(32'd5000);
        run_beats(2, {3{16'd10}}, {3{16'd256}}, 1'b0, 1'b0);
        #2;
        Resetn = 1'b0;
        #1;
        chk("arst_acc", acc_raw, 96'd0);
        chk("arst_res", 96'(result), 96'd0);
        chk("arst_busy", 96'(busy), 96'd0);
        chk("arst_in_ready", 96'(in_ready), 96'd0);
        chk("arst_ov", 96'(out_valid), 96'd0);
        tick();
        Resetn = 1'b1;
        tick();

        // fresh run after reset
        do_start(32'd0);
        run_beats(6, {3{16'd10}}, {3{16'd256}}, 1'b0, 1'b0);
        exp_acc = {3{32'd15360}};
        finish_run("postrst", exp_acc, {3{8'd60}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
